// File: rtl/sc_shiftarbiter_jug.sv
// Two-player move arbiter driving the shared position shift register.
// Enforces one shift per press, boundary limits, round-robin fairness and a post-move cooldown.
module sc_shiftarbiter_jug #(
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned COOLDOWN_WIDTH  = 4
) (
    input  logic       SC_SHIFTARBITER_JUG_CLOCK_50,
    input  logic       SC_SHIFTARBITER_JUG_RESET_InLow,
    input  logic       SC_SHIFTARBITER_JUG_startButton_InLow,
    input  logic       SC_SHIFTARBITER_JUG_jug1Left_InLow,
    input  logic       SC_SHIFTARBITER_JUG_jug1Right_InLow,
    input  logic       SC_SHIFTARBITER_JUG_jug2Left_InLow,
    input  logic       SC_SHIFTARBITER_JUG_jug2Right_InLow,
    input  logic       SC_SHIFTARBITER_JUG_leftLimit_InLow,
    input  logic       SC_SHIFTARBITER_JUG_rightLimit_InLow,
    output logic       SC_SHIFTARBITER_JUG_clear_OutLow,
    output logic [1:0] SC_SHIFTARBITER_JUG_shiftselection_Out,
    output logic [1:0] SC_SHIFTARBITER_JUG_grant_Out,
    output logic       SC_SHIFTARBITER_JUG_busy_Out
);

    localparam logic [1:0] SEL_HOLD   = 2'b11;
    localparam logic [1:0] SEL_LEFT   = 2'b01;
    localparam logic [1:0] SEL_RIGHT  = 2'b10;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_JUG1 = 2'b01;
    localparam logic [1:0] GRANT_JUG2 = 2'b10;

    typedef enum logic [2:0] {
        RESET    = 3'd0,
        CLEAR    = 3'd1,
        IDLE     = 3'd2,
        MOVE     = 3'd3,
        COOLDOWN = 3'd4
    } stateT;

    stateT                     state;
    logic                      startArmed;
    logic                      jug1Armed;
    logic                      jug2Armed;
    logic                      rrPtr;
    logic [COOLDOWN_WIDTH-1:0] coolCount;

    logic       startValid;
    logic       jug1Valid;
    logic       jug2Valid;
    logic       pickJug2;
    logic [1:0] jug1Dir;
    logic [1:0] jug2Dir;

    // Request qualification: armed, exactly one button low, and that side not at its limit.
    always_comb begin
        startValid = startArmed && !SC_SHIFTARBITER_JUG_startButton_InLow;
        jug1Valid  = jug1Armed
                  && (SC_SHIFTARBITER_JUG_jug1Left_InLow ^ SC_SHIFTARBITER_JUG_jug1Right_InLow)
                  && (SC_SHIFTARBITER_JUG_jug1Left_InLow ? SC_SHIFTARBITER_JUG_rightLimit_InLow
                                                         : SC_SHIFTARBITER_JUG_leftLimit_InLow);
        jug2Valid  = jug2Armed
                  && (SC_SHIFTARBITER_JUG_jug2Left_InLow ^ SC_SHIFTARBITER_JUG_jug2Right_InLow)
                  && (SC_SHIFTARBITER_JUG_jug2Left_InLow ? SC_SHIFTARBITER_JUG_rightLimit_InLow
                                                         : SC_SHIFTARBITER_JUG_leftLimit_InLow);
        jug1Dir    = SC_SHIFTARBITER_JUG_jug1Left_InLow ? SEL_RIGHT : SEL_LEFT;
        jug2Dir    = SC_SHIFTARBITER_JUG_jug2Left_InLow ? SEL_RIGHT : SEL_LEFT;
        pickJug2   = jug2Valid && (!jug1Valid || rrPtr);
    end

    // State, arming and registered outputs; the output registers double as the direction/grant latches.
    always_ff @(posedge SC_SHIFTARBITER_JUG_CLOCK_50) begin
        if (!SC_SHIFTARBITER_JUG_RESET_InLow) begin
            state                                  <= RESET;
            startArmed                             <= 1'b0;
            jug1Armed                              <= 1'b0;
            jug2Armed                              <= 1'b0;
            rrPtr                                  <= 1'b0;
            coolCount                              <= '0;
            SC_SHIFTARBITER_JUG_clear_OutLow       <= 1'b0;
            SC_SHIFTARBITER_JUG_shiftselection_Out <= SEL_HOLD;
            SC_SHIFTARBITER_JUG_grant_Out          <= GRANT_NONE;
            SC_SHIFTARBITER_JUG_busy_Out           <= 1'b0;
        end else begin
            SC_SHIFTARBITER_JUG_clear_OutLow       <= 1'b1;
            SC_SHIFTARBITER_JUG_shiftselection_Out <= SEL_HOLD;
            SC_SHIFTARBITER_JUG_grant_Out          <= GRANT_NONE;
            SC_SHIFTARBITER_JUG_busy_Out           <= 1'b0;

            // Buttons must be seen released before they can act again.
            if (state != RESET) begin
                if (SC_SHIFTARBITER_JUG_startButton_InLow)
                    startArmed <= 1'b1;
                if (SC_SHIFTARBITER_JUG_jug1Left_InLow && SC_SHIFTARBITER_JUG_jug1Right_InLow)
                    jug1Armed <= 1'b1;
                if (SC_SHIFTARBITER_JUG_jug2Left_InLow && SC_SHIFTARBITER_JUG_jug2Right_InLow)
                    jug2Armed <= 1'b1;
            end

            case (state)
                RESET: begin
                    state                            <= CLEAR;
                    SC_SHIFTARBITER_JUG_clear_OutLow <= 1'b0;
                end
                CLEAR: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (startValid) begin
                        state                            <= CLEAR;
                        startArmed                       <= 1'b0;
                        SC_SHIFTARBITER_JUG_clear_OutLow <= 1'b0;
                    end else if (jug1Valid || jug2Valid) begin
                        state                        <= MOVE;
                        rrPtr                        <= !rrPtr;
                        SC_SHIFTARBITER_JUG_busy_Out <= 1'b1;
                        if (pickJug2) begin
                            jug2Armed                              <= 1'b0;
                            SC_SHIFTARBITER_JUG_grant_Out          <= GRANT_JUG2;
                            SC_SHIFTARBITER_JUG_shiftselection_Out <= jug2Dir;
                        end else begin
                            jug1Armed                              <= 1'b0;
                            SC_SHIFTARBITER_JUG_grant_Out          <= GRANT_JUG1;
                            SC_SHIFTARBITER_JUG_shiftselection_Out <= jug1Dir;
                        end
                    end
                end
                MOVE: begin
                    if (COOLDOWN_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        state                        <= COOLDOWN;
                        coolCount                    <= COOLDOWN_WIDTH'(COOLDOWN_CYCLES);
                        SC_SHIFTARBITER_JUG_busy_Out <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (startValid) begin
                        state                            <= CLEAR;
                        startArmed                       <= 1'b0;
                        SC_SHIFTARBITER_JUG_clear_OutLow <= 1'b0;
                    end else begin
                        coolCount <= coolCount - COOLDOWN_WIDTH'(1);
                        if (coolCount == COOLDOWN_WIDTH'(1))
                            state <= IDLE;
                        else
                            SC_SHIFTARBITER_JUG_busy_Out <= 1'b1;
                    end
                end
                default: begin
                    state                            <= RESET;
                    SC_SHIFTARBITER_JUG_clear_OutLow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_shiftarbiter_jug.sv
// Bench for sc_shiftarbiter_jug: directed scenarios then random traffic,
// compared each cycle against a timestamp-based reference model.
module tb_sc_shiftarbiter_jug;

    localparam int unsigned COOL = 8;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       startB = 1'b1;
    logic       j1l = 1'b1, j1r = 1'b1, j2l = 1'b1, j2r = 1'b1;
    logic       leftLim = 1'b1, rightLim = 1'b1;
    logic       clearOut;
    logic [1:0] selOut;
    logic [1:0] grantOut;
    logic       busyOut;

    int compared   = 0;
    int mismatched = 0;
    int grantSeen  = 0;

    // Reference model: cycle index plus the cycle numbers of the last reset, clear and move.
    int         n      = 0;
    int         tReset = -1000;
    int         tClear = -1000;
    int         tMove  = -1000;
    bit         aStart = 0, a1 = 0, a2 = 0;
    bit         nextIsJug2 = 0;
    logic [1:0] mDir   = 2'b11;
    logic [1:0] mGrant = 2'b00;

    sc_shiftarbiter_jug #(.COOLDOWN_CYCLES(COOL), .COOLDOWN_WIDTH(4)) dut (
        .SC_SHIFTARBITER_JUG_CLOCK_50          (clk),
        .SC_SHIFTARBITER_JUG_RESET_InLow       (rstN),
        .SC_SHIFTARBITER_JUG_startButton_InLow (startB),
        .SC_SHIFTARBITER_JUG_jug1Left_InLow    (j1l),
        .SC_SHIFTARBITER_JUG_jug1Right_InLow   (j1r),
        .SC_SHIFTARBITER_JUG_jug2Left_InLow    (j2l),
        .SC_SHIFTARBITER_JUG_jug2Right_InLow   (j2r),
        .SC_SHIFTARBITER_JUG_leftLimit_InLow   (leftLim),
        .SC_SHIFTARBITER_JUG_rightLimit_InLow  (rightLim),
        .SC_SHIFTARBITER_JUG_clear_OutLow      (clearOut),
        .SC_SHIFTARBITER_JUG_shiftselection_Out(selOut),
        .SC_SHIFTARBITER_JUG_grant_Out         (grantOut),
        .SC_SHIFTARBITER_JUG_busy_Out          (busyOut)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [1:0] got, input logic [1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, n, got, exp);
        end
    endtask

    function automatic bit coolAt(input int c);
        return (c > tMove) && (c <= tMove + int'(COOL)) && (tMove > tClear) && (tMove > tReset);
    endfunction

    function automatic bit playerValid(input bit armed, input logic l, input logic r);
        int pressed;
        pressed = (l ? 0 : 1) + (r ? 0 : 1);
        if (!armed || pressed != 1) return 0;
        return !l ? leftLim : rightLim;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
    task automatic step();
        bit isReset, isClear, isMove, inCool, isIdle, v1, v2, sv, g2;
        @(posedge clk);
        isReset = (n == tReset);
        isClear = (n == tClear);
        isMove  = (n == tMove);
        inCool  = coolAt(n);
        isIdle  = !isReset && !isClear && !isMove && !inCool;
        v1 = playerValid(a1, j1l, j1r);
        v2 = playerValid(a2, j2l, j2r);
        sv = aStart && !startB;
        if (!rstN) begin
            tReset = n + 1;
            aStart = 0; a1 = 0; a2 = 0; nextIsJug2 = 0;
        end else begin
            if (!isReset) begin
                if (startB) aStart = 1;
                if (j1l && j1r) a1 = 1;
                if (j2l && j2r) a2 = 1;
            end
            if (isReset) begin
                tClear = n + 1;
            end else if ((isIdle || inCool) && sv) begin
                tClear = n + 1;
                aStart = 0;
            end else if (isIdle && (v1 || v2)) begin
                g2 = v1 && v2 ? nextIsJug2 : v2;
                tMove = n + 1;
                nextIsJug2 = !nextIsJug2;
                if (g2) begin
                    mGrant = 2'b10; mDir = !j2l ? 2'b01 : 2'b10; a2 = 0;
                end else begin
                    mGrant = 2'b01; mDir = !j1l ? 2'b01 : 2'b10; a1 = 0;
                end
            end
        end
        n++;
        #1;
        checkVal("clear_OutLow",   {1'b0, clearOut}, {1'b0, !(n == tReset || n == tClear)});
        checkVal("busy_Out",       {1'b0, busyOut},  {1'b0, (n == tMove) || coolAt(n)});
        checkVal("shiftselection", selOut,           (n == tMove) ? mDir : 2'b11);
        checkVal("grant_Out",      grantOut,         (n == tMove) ? mGrant : 2'b00);
        if (grantOut != 2'b00) grantSeen++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int g0;
        // Reset held with jug1Left low; the held button must not act after release.
        j1l = 1'b0;
        steps(3);
        rstN = 1'b1;
        g0 = grantSeen;
        steps(6);
        checkVal("held_through_reset", 2'(grantSeen - g0), 2'd0);
        j1l = 1'b1; step();
        j1l = 1'b0; steps(2);
        j1l = 1'b1; steps(12);

        // A long press yields exactly one move.
        g0 = grantSeen;
        j1r = 1'b0; steps(20);
        checkVal("one_move_per_press", 2'(grantSeen - g0), 2'd1);
        j1r = 1'b1; steps(12);

        // Contended press, then the loser after cooldown, then jug1 again.
        j1l = 1'b0; j2r = 1'b0; steps(25);
        j1l = 1'b1; j2r = 1'b1; steps(2);
        j1l = 1'b0; j2r = 1'b0; steps(12);
        j1l = 1'b1; j2r = 1'b1; steps(12);

        // Left limit blocks a left move until released.
        leftLim = 1'b0; j2l = 1'b0; steps(5);
        leftLim = 1'b1; steps(12);
        j2l = 1'b1; steps(3);

        // Start during cooldown aborts it; held start clears only once.
        j1l = 1'b0; steps(5);
        j1l = 1'b1; startB = 1'b0; steps(8);
        startB = 1'b1; steps(12);

        // Reset during a move, then a contended pair goes to jug1.
        j2r = 1'b0; step();
        rstN = 1'b0; step();
        checkVal("reset_mid_move_grant", grantOut, 2'b00);
        rstN = 1'b1; j2r = 1'b1; steps(4);
        j1r = 1'b0; j2l = 1'b0; steps(3);
        j1r = 1'b1; j2l = 1'b1; steps(12);

        // Random traffic with sticky buttons, occasional limits, start and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) j1l = ~j1l;
            if ($urandom_range(0, 5) == 0) j1r = ~j1r;
            if ($urandom_range(0, 5) == 0) j2l = ~j2l;
            if ($urandom_range(0, 5) == 0) j2r = ~j2r;
            if ($urandom_range(0, 15) == 0) leftLim = ~leftLim;
            if ($urandom_range(0, 15) == 0) rightLim = ~rightLim;
            startB = ($urandom_range(0, 40) == 0) ? ~startB : startB;
            rstN = ($urandom_range(0, 250) != 0);
            step();
        end
        rstN = 1'b1;
        steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
